// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default
// latencies and sequencer state codes.
package mdu_pkg;

   localparam logic [2:0] MDU_NONE  = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;

   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, rs, rt, input busy, hi, lo);
   modport slave  (input start, op, rs, rt, output busy, hi, lo);

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: full 64-bit product, or quotient/remainder for the
// selected op, computed in one shot; the sequencer only models latency.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_zero
);

   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   // Signed ops go through magnitudes so the -2^31 / -1 case wraps cleanly.
   always_comb begin
      a_ext    = (op == MDU_MULT) ? {{32{rs[31]}}, rs} : {32'd0, rs};
      b_ext    = (op == MDU_MULT) ? {{32{rt[31]}}, rt} : {32'd0, rt};
      prod     = a_ext * b_ext;

      div_zero = is_div_op(op) && (rt == 32'd0);
      neg_a    = (op == MDU_DIV) && rs[31];
      neg_b    = (op == MDU_DIV) && rt[31];
      mag_a    = neg_a ? (32'd0 - rs) : rs;
      mag_b    = neg_b ? (32'd0 - rt) : rt;
      divisor  = div_zero ? 32'd1 : mag_b;
      q_mag    = mag_a / divisor;
      r_mag    = mag_a % divisor;
      quot     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
      rem      = neg_a ? (32'd0 - r_mag) : r_mag;

      res_hi   = 32'd0;
      res_lo   = 32'd0;
      case (op)
         MDU_MULT, MDU_MULTU: {res_hi, res_lo} = prod;
         MDU_DIV, MDU_DIVU: begin
            res_hi = rem;
            res_lo = quot;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, parks the result in pending
// registers and commits it when the busy counter expires.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic             pend_we_q, pend_we_d;

   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             div_zero;

   mdu_arith u_arith (
      .op       (bus.op),
      .rs       (bus.rs),
      .rt       (bus.rt),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   // state_q mirrors (cnt_q != 0) but comes straight from a flop, so busy is glitch-free.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;

      if (state_q == ST_IDLE) begin
         if (bus.start) begin
            case (bus.op)
               MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  pend_we_d = !div_zero;
                  cnt_d     = is_div_op(bus.op) ? DIV_LOAD : MULT_LOAD;
                  state_d   = ST_RUN;
               end
               MDU_MTHI: hi_d = bus.rs;
               MDU_MTLO: lo_d = bus.rs;
               default: ;
            endcase
         end
      end else begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            if (pend_we_q) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized bench for mdu_ctrl against an arithmetic model of
// the architectural HI/LO registers and the fixed op latencies.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mdu_if bus ();

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; returns latency, updates exp_hi/exp_lo.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
      longint      sa, sb, p, q, r;
      logic [63:0] pu;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = 0;
      case (op)
         3'd1: begin
            p = sa * sb;
            {exp_hi, exp_lo} = 64'(p);
            lat = MULT_LAT;
         end
         3'd2: begin
            pu = {32'd0, a} * {32'd0, b};
            {exp_hi, exp_lo} = pu;
            lat = MULT_LAT;
         end
         3'd3: begin
            if (b != 32'd0) begin
               q = sa / sb;
               r = sa % sb;
               exp_lo = q[31:0];
               exp_hi = r[31:0];
            end
            lat = DIV_LAT;
         end
         3'd4: begin
            if (b != 32'd0) begin
               exp_lo = a / b;
               exp_hi = a % b;
            end
            lat = DIV_LAT;
         end
         3'd5: exp_hi = a;
         3'd6: exp_lo = a;
         default: ;
      endcase
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj_at,
                         input logic [2:0] inj_op, input logic [31:0] inj_rs);
      logic [31:0] old_hi, old_lo;
      int lat, cycles;
      old_hi = exp_hi;
      old_lo = exp_lo;
      model_op(op, a, b, lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.rs    = a;
      bus.rt    = b;
      tick();
      bus.start = 1'b0;
      bus.op    = 3'($urandom);
      bus.rs    = $urandom;
      bus.rt    = $urandom;
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < lat + 5) begin
         cycles++;
         check({tag, "_hold_hi"}, bus.hi, old_hi);
         check({tag, "_hold_lo"}, bus.lo, old_lo);
         if (cycles == inj_at) begin
            bus.start = 1'b1;
            bus.op    = inj_op;
            bus.rs    = inj_rs;
         end
         tick();
         bus.start = 1'b0;
      end
      check({tag, "_busy_cycles"}, 32'(cycles), 32'(lat));
      check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      check({tag, "_hi"}, bus.hi, exp_hi);
      check({tag, "_lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      logic [31:0] corners [6];
      logic [31:0] a, b;
      logic [2:0]  op;

      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = MDU_NONE;
      bus.rs    = 32'd0;
      bus.rt    = 32'd0;
      tick();
      tick();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);
      reset = 1'b1;
      tick();

      $display("[TB] directed sequence");
      run_op("mult", MDU_MULT, 32'h8000_0000, 32'hFFFF_FFFF, -1, MDU_NONE, 32'd0);
      check("mult_hi_const", bus.hi, 32'h0000_0000);
      check("mult_lo_const", bus.lo, 32'h8000_0000);

      run_op("multu", MDU_MULTU, 32'h8000_0000, 32'hFFFF_FFFF, -1, MDU_NONE, 32'd0);
      check("multu_hi_const", bus.hi, 32'h7FFF_FFFF);
      check("multu_lo_const", bus.lo, 32'h8000_0000);

      run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1, MDU_NONE, 32'd0);
      check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
      check("div_hi_const", bus.hi, 32'hFFFF_FFFF);

      run_op("divu", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, -1, MDU_NONE, 32'd0);
      check("divu_lo_const", bus.lo, 32'h7FFF_FFFC);
      check("divu_hi_const", bus.hi, 32'h0000_0001);

      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, MDU_NONE, 32'd0);
      check("div_ovf_lo_const", bus.lo, 32'h8000_0000);
      check("div_ovf_hi_const", bus.hi, 32'h0000_0000);

      run_op("mthi", MDU_MTHI, 32'h1234_5678, 32'd0, -1, MDU_NONE, 32'd0);
      check("mthi_const", bus.hi, 32'h1234_5678);
      run_op("div0", MDU_DIV, 32'd77, 32'd0, -1, MDU_NONE, 32'd0);
      check("div0_hi_const", bus.hi, 32'h1234_5678);

      run_op("mult_inj", MDU_MULT, 32'd1000, 32'hFFFF_FFFE, 2, MDU_MTLO, 32'hDEAD_BEEF);
      check("mult_inj_lo_const", bus.lo, 32'hFFFF_F830);

      $display("[TB] reset during divide");
      bus.start = 1'b1;
      bus.op    = MDU_DIV;
      bus.rs    = 32'd100;
      bus.rt    = 32'd7;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_hi", bus.hi, 32'd0);
      check("rst_mid_lo", bus.lo, 32'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("rst_after_busy", 32'(bus.busy), 32'd0);
         check("rst_after_hi", bus.hi, 32'd0);
         check("rst_after_lo", bus.lo, 32'd0);
      end

      $display("[TB] randomized sequence");
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
         run_op("rand", op, a, b,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1,
                3'($urandom_range(1, 6)), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the MIPS pipeline EX stage. It accepts one MD operation at a time on rs/rt and computes signed or unsigned results. It holds the architectural HI/LO registers and models the fixed operation latency with a busy counter. Its registered busy output drives the hazard unit so that later MD instructions and mfhi/mflo stall.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  launch request from EX, qualified by op
op  in  3  operation code (see package)
rs  in  32  operand A (dividend / multiplicand / mthi-mtlo source)
rt  in  32  operand B (divisor / multiplier)
busy  out  1  high while an operation is in flight
hi  out  32  architectural HI register
lo  out  32  architectural LO register

Behaviour:
- Reset (reset==0, any time, including mid-operation): busy=0, counter=0, hi=0, lo=0, pending result discarded. State=IDLE.
- States:
  - IDLE: counter==0, busy=0.
  - RUN: counter!=0, busy=1. busy is driven directly from (counter!=0), registered and glitch-free.
- IDLE with start=1:
  - op MULT/MULTU: at the launch edge, latch the 64-bit product into pend_hi/pend_lo and load counter=MULT_CYCLES. Go to RUN.
  - op DIV/DIVU: latch quotient into pend_lo and remainder into pend_hi; load counter=DIV_CYCLES. Go to RUN.
  - op MTHI/MTLO: write rs into hi/lo at that edge. busy stays 0, stay IDLE.
  - op NONE or an undefined code: no effect.
- RUN:
  - counter decrements on every edge.
  - On the edge where counter goes 1->0: hi<=pend_hi, lo<=pend_lo, busy falls. The new hi/lo values and busy=0 appear in the same cycle.
  - Latency: start sampled at edge k gives busy=1 for exactly N cycles and the result visible after edge k+N.
- start during RUN, any op including MTHI/MTLO: ignored with no state change. The hazard unit guarantees this never happens; the bench checks that the block tolerates it.
- hi/lo keep their old values throughout RUN; mfhi/mflo must stall externally.
- Arithmetic:
  - MULT: signed 32x32->64.
  - MULTU: unsigned 32x32->64.
  - DIV: truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Divide by zero (rt==0, DIV or DIVU): the full DIV_CYCLES busy sequence runs, then hi/lo are left unchanged (pending write suppressed).
- Operands are sampled only at the launch edge; rs/rt changes during RUN have no effect.

Decomposition:
- Package mdu_pkg holds the op encoding as 3-bit constants: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6. It also holds the default cycle counts. The decoder and the hazard unit use the same package.
- Sub-module mdu_arith: purely combinational; inputs op, rs, rt; outputs res_hi, res_lo and div_zero.
- mdu_ctrl keeps the FSM/counter, the pending registers and the architectural HI/LO.

Test Plan:
1. MULT, rs=0x8000_0000, rt=0xFFFF_FFFF -> busy high exactly 5 cycles; then hi=0x0000_0000, lo=0x8000_0000.
2. MULTU with the same operands -> after 5 cycles hi=0x7FFF_FFFF, lo=0x8000_0000; hi/lo hold their prior values during busy.
3. DIV rs=0xFFFF_FFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
   DIVU with the same operands -> lo=0x7FFF_FFFC, hi=0x0000_0001.
4. MTHI rs=0x1234_5678 -> hi updates at the next edge, busy stays 0.
   Then DIV rt=0 -> busy 10 cycles, hi stays 0x1234_5678.
5. MULT launched, then start MTLO rs=0xDEAD_BEEF at cycle 2 of busy -> ignored.
   Result is the MULT product; busy still lasts exactly 5 cycles.
6. DIV launched, reset pulled low at busy cycle 4 -> busy=0, hi=lo=0 immediately.
   After release, no delayed write to hi/lo occurs.
